// File: rtl/ysyx_23060208_lsu.sv
// Load/store unit: one request per transaction, issued as a single-beat
// AXI4 read or write. Handles lane steering, strobes, load extension,
// misalignment and bus-error reporting. Every AXI/req-side output is
// either a register or a decode of the state register.
module ysyx_23060208_lsu #(
    parameter int           ADDR_WIDTH = 32,
    parameter int           XLEN       = 32,
    parameter int           BUS_WIDTH  = 64,
    parameter logic [3:0]   AXI_ID     = 4'h1,
    localparam int          BUS_BYTES  = BUS_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset,
    // request / response
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [XLEN-1:0]       req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [XLEN-1:0]       resp_rdata_o,
    output logic [1:0]            resp_err_o,
    // AXI write address / data / response
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic [3:0]            awid_o,
    output logic [7:0]            awlen_o,
    output logic [2:0]            awsize_o,
    output logic [1:0]            awburst_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    output logic [BUS_WIDTH-1:0]  wdata_o,
    output logic [BUS_BYTES-1:0]  wstrb_o,
    output logic                  wlast_o,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    input  logic [1:0]            bresp_i,
    input  logic [3:0]            bid_i,
    // AXI read address / data
    output logic                  arvalid_o,
    input  logic                  arready_i,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic [3:0]            arid_o,
    output logic [7:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    input  logic [BUS_WIDTH-1:0]  rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic [3:0]            rid_i
);
    localparam int OFFW = $clog2(BUS_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_RADDR, S_RDATA, S_WREQ, S_WRESP, S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              size_q;
    logic                    signed_q;
    logic [OFFW-1:0]         off_q;
    logic [BUS_WIDTH-1:0]    wbus_q;
    logic [BUS_BYTES-1:0]    wstrb_q;
    logic                    aw_pend_q, w_pend_q;
    logic [XLEN-1:0]         rdata_q;
    logic [1:0]              err_q;

    // Single-beat, one-ID master: IDs, responses' rlast are of no interest.
    logic unused_ok;
    assign unused_ok = ^{rid_i, bid_i, rlast_i};

    logic accept;
    assign accept = (state_q == S_IDLE) && req_valid_i;

    // Request-side decode: misalignment, store lane steering and strobes.
    logic                 misal;
    logic [OFFW-1:0]      st_off;
    logic [BUS_WIDTH-1:0] st_data;
    logic [BUS_BYTES-1:0] strb_base, st_strb;

    // Decode the incoming request into alignment check, bus data and strobes.
    always_comb begin
        st_off    = req_addr_i[OFFW-1:0];
        st_data   = BUS_WIDTH'(req_wdata_i) << {st_off, 3'b000};
        strb_base = '0;
        misal     = 1'b0;
        case (req_size_i)
            2'd0: begin strb_base = BUS_BYTES'(1);   misal = 1'b0; end
            2'd1: begin strb_base = BUS_BYTES'(3);   misal = req_addr_i[0]; end
            2'd2: begin strb_base = BUS_BYTES'(15);  misal = |req_addr_i[1:0]; end
            default: begin
                strb_base = BUS_BYTES'(255);
                misal     = (|req_addr_i[2:0]) | (XLEN == 32);
            end
        endcase
        st_strb = strb_base << st_off;
    end

    // Load path: shift the addressed bytes down, then extend to XLEN.
    logic [BUS_WIDTH-1:0] r_shift;
    logic [7:0]           nbits;
    logic                 msb;
    logic [XLEN-1:0]      ld_data;

    // Extract and sign/zero-extend the load value from the read beat.
    always_comb begin
        r_shift = rdata_i >> {off_q, 3'b000};
        nbits   = 8'd8 << size_q;
        case (size_q)
            2'd0:    msb = r_shift[7];
            2'd1:    msb = r_shift[15];
            2'd2:    msb = r_shift[31];
            default: msb = r_shift[XLEN-1];
        endcase
        ld_data = '0;
        for (int i = 0; i < XLEN; i++)
            ld_data[i] = (i < int'(nbits)) ? r_shift[i] : (signed_q & msb);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; write request completes once both AW and W are done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid_i)
                         state_d = misal ? S_RESP : (req_we_i ? S_WREQ : S_RADDR);
            S_RADDR: if (arready_i) state_d = S_RDATA;
            S_RDATA: if (rvalid_i)  state_d = S_RESP;
            S_WREQ:  if ((!aw_pend_q || awready_i) && (!w_pend_q || wready_i))
                         state_d = S_WRESP;
            S_WRESP: if (bvalid_i)  state_d = S_RESP;
            S_RESP:  if (resp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, write-channel pending flags and response capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q    <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
            off_q     <= '0;
            wbus_q    <= '0;
            wstrb_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= '0;
        end else begin
            if (accept) begin
                addr_q    <= req_addr_i;
                size_q    <= req_size_i;
                signed_q  <= req_signed_i;
                off_q     <= st_off;
                wbus_q    <= st_data;
                wstrb_q   <= st_strb;
                aw_pend_q <= req_we_i & ~misal;
                w_pend_q  <= req_we_i & ~misal;
                rdata_q   <= '0;
                err_q     <= {1'b0, misal};
            end
            if (state_q == S_WREQ) begin
                if (awready_i) aw_pend_q <= 1'b0;
                if (wready_i)  w_pend_q  <= 1'b0;
            end
            if (state_q == S_RDATA && rvalid_i) begin
                rdata_q <= ld_data;
                err_q   <= {rresp_i != 2'b00, 1'b0};
            end
            if (state_q == S_WRESP && bvalid_i)
                err_q <= {bresp_i != 2'b00, 1'b0};
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    assign arvalid_o = (state_q == S_RADDR);
    assign rready_o  = (state_q == S_RDATA);
    assign araddr_o  = addr_q;
    assign arid_o    = AXI_ID;
    assign arlen_o   = 8'd0;
    assign arsize_o  = {1'b0, size_q};
    assign arburst_o = 2'b01;

    assign awvalid_o = aw_pend_q;
    assign wvalid_o  = w_pend_q;
    assign bready_o  = (state_q == S_WRESP);
    assign awaddr_o  = addr_q;
    assign awid_o    = AXI_ID;
    assign awlen_o   = 8'd0;
    assign awsize_o  = {1'b0, size_q};
    assign awburst_o = 2'b01;
    assign wdata_o   = wbus_q;
    assign wstrb_o   = wstrb_q;
    assign wlast_o   = 1'b1;
endmodule
